// File: rtl/rect_ctrl_sequencer.sv
// ============================================================================
// Module   : rect_ctrl_sequencer
// Brief    : Handshake-driven sequencer for one rectifier control step
//            (outer PI -> inner PI pair -> PWM start). Optional completed-step
//            counter enabled by macro RECT_SEQ_STEP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_ctrl_sequencer #(
    parameter int D_PRE     = 9,
    parameter int D_READ_IN = 31,
    parameter int D_SUB     = 7,
    parameter int D_PWM     = 16,
    parameter int TIMEOUT   = 255,
    parameter int CW        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rst_user,
    input  logic        sta_user,
    input  logic        sta,
    input  logic        pi_outer_done,
    input  logic        pi_inner_done,
    output logic        pi_outer_sta,
    output logic        inner_read_x,
    output logic        pi_inner_sta,
    output logic        pwm_sta,
    output logic        busy,
    output logic        overrun,
    output logic        timeout,
    output logic [15:0] step_count
);

    localparam logic [CW-1:0] c_one = CW'(1);
    localparam logic [CW-1:0] c_pre = CW'(D_PRE);
    localparam logic [CW-1:0] c_rd  = CW'(D_READ_IN);
    localparam logic [CW-1:0] c_sub = CW'(D_SUB);
    localparam logic [CW-1:0] c_pwm = CW'(D_PWM);
    localparam logic [CW-1:0] c_to  = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRE      = 3'd1,
        S_OUT_WAIT = 3'd2,
        S_SUB      = 3'd3,
        S_IN_WAIT  = 3'd4,
        S_CONV     = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] dly_q, dly_d;
    logic [CW-1:0] abs_q, abs_d;
    logic          rd_done_q, rd_done_d;
    logic          outer_sta_q, outer_sta_d;
    logic          read_q, read_d;
    logic          inner_sta_q, inner_sta_d;
    logic          pwm_q, pwm_d;
    logic          busy_q, busy_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic          go;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + c_one;
    endfunction

    assign go = sta & sta_user;

    always_comb begin
        state_d     = state_q;
        dly_d       = sat_inc(dly_q);
        abs_d       = (state_q == S_IDLE) ? abs_q : sat_inc(abs_q);
        rd_done_d   = rd_done_q;
        outer_sta_d = 1'b0;
        read_d      = 1'b0;
        inner_sta_d = 1'b0;
        pwm_d       = 1'b0;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;

        // dly counts clocks since the edge that started the current phase.
        case (state_q)
            S_IDLE: begin
                dly_d = '0;
                if (go) begin
                    dly_d     = c_one;
                    abs_d     = c_one;
                    rd_done_d = 1'b0;
                    if (c_pre == c_one) begin
                        outer_sta_d = 1'b1;
                        state_d     = S_OUT_WAIT;
                    end else begin
                        state_d = S_PRE;
                    end
                end
            end
            S_PRE: begin
                if (dly_d == c_pre) begin
                    outer_sta_d = 1'b1;
                    dly_d       = c_one;
                    state_d     = S_OUT_WAIT;
                end
            end
            S_OUT_WAIT: begin
                if (pi_outer_done) begin
                    dly_d = c_one;
                    if (c_one >= c_sub && rd_done_q) begin
                        inner_sta_d = 1'b1;
                        state_d     = S_IN_WAIT;
                    end else begin
                        state_d = S_SUB;
                    end
                end else if (dly_q == c_to) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_SUB: begin
                // Inner PI must not start before its operands have been read.
                if (dly_d >= c_sub && rd_done_q) begin
                    inner_sta_d = 1'b1;
                    dly_d       = c_one;
                    state_d     = S_IN_WAIT;
                end
            end
            S_IN_WAIT: begin
                if (pi_inner_done) begin
                    dly_d = c_one;
                    if (c_pwm == c_one) begin
                        pwm_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CONV;
                    end
                end else if (dly_q == c_to) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_CONV: begin
                if (dly_d == c_pwm) begin
                    pwm_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end

        if (!rd_done_d && state_d != S_IDLE && abs_d == c_rd) begin
            read_d    = 1'b1;
            rd_done_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE) | pwm_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dly_q       <= '0;
            abs_q       <= '0;
            rd_done_q   <= 1'b0;
            outer_sta_q <= 1'b0;
            read_q      <= 1'b0;
            inner_sta_q <= 1'b0;
            pwm_q       <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else if (rst_user) begin
            state_q     <= S_IDLE;
            dly_q       <= '0;
            abs_q       <= '0;
            rd_done_q   <= 1'b0;
            outer_sta_q <= 1'b0;
            read_q      <= 1'b0;
            inner_sta_q <= 1'b0;
            pwm_q       <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            abs_q       <= abs_d;
            rd_done_q   <= rd_done_d;
            outer_sta_q <= outer_sta_d;
            read_q      <= read_d;
            inner_sta_q <= inner_sta_d;
            pwm_q       <= pwm_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef RECT_SEQ_STEP_CNT_EN
    logic [15:0] step_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= '0;
        end else if (rst_user) begin
            step_q <= '0;
        end else if (pwm_d) begin
            step_q <= step_q + 16'd1;
        end
    end

    assign step_count = step_q;
`else
    assign step_count = '0;
`endif

    assign pi_outer_sta = outer_sta_q;
    assign inner_read_x = read_q;
    assign pi_inner_sta = inner_sta_q;
    assign pwm_sta      = pwm_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rect_ctrl_sequencer.sv
// ============================================================================
// Module   : tb_rect_ctrl_sequencer
// Brief    : Scoreboard bench for rect_ctrl_sequencer with directed steps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rect_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_user = 1'b0;
    logic        sta_user = 1'b1;
    logic        sta = 1'b0;
    logic        pi_outer_done = 1'b0;
    logic        pi_inner_done = 1'b0;
    logic        pi_outer_sta, inner_read_x, pi_inner_sta, pwm_sta;
    logic        busy, overrun, timeout;
    logic [15:0] step_count;

    rect_ctrl_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .rst_user      (rst_user),
        .sta_user      (sta_user),
        .sta           (sta),
        .pi_outer_done (pi_outer_done),
        .pi_inner_done (pi_inner_done),
        .pi_outer_sta  (pi_outer_sta),
        .inner_read_x  (inner_read_x),
        .pi_inner_sta  (pi_inner_sta),
        .pwm_sta       (pwm_sta),
        .busy          (busy),
        .overrun       (overrun),
        .timeout       (timeout),
        .step_count    (step_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    int    steps  = 0;
    string kname[4] = '{"pi_outer_sta", "inner_read_x", "pi_inner_sta", "pwm_sta"};

    function automatic void push(input int kind, input int at_cyc);
        exp_t e;
        e.kind = kind;
        e.at   = at_cyc;
        q.push_back(e);
    endfunction

    function automatic logic [15:0] exp_steps();
`ifdef RECT_SEQ_STEP_CNT_EN
        return 16'(steps);
`else
        return 16'd0;
`endif
    endfunction

    task automatic pop_cmp(input int kind);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL pulse: unexpected %s at cycle %0d (nothing expected)", kname[kind], cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.at != cyc) begin
                errors++;
                $display("FAIL pulse: got %s at cycle %0d, expected %s at cycle %0d",
                         kname[kind], cyc, kname[e.kind], e.at);
            end
        end
    endtask

    // Monitor: every output pulse is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (pi_outer_sta) pop_cmp(0);
            if (inner_read_x) pop_cmp(1);
            if (pi_inner_sta) pop_cmp(2);
            if (pwm_sta)      pop_cmp(3);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance to the negedge inside cycle c, clearing single-cycle pulses.
    task automatic at(input int c);
        while (cyc < c) begin
            @(negedge clk);
            sta           = 1'b0;
            pi_outer_done = 1'b0;
            pi_inner_done = 1'b0;
            rst_user      = 1'b0;
        end
    endtask

    int b;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outer_sta", {15'd0, pi_outer_sta}, 16'd0);
        chk("rst_read", {15'd0, inner_read_x}, 16'd0);
        chk("rst_inner_sta", {15'd0, pi_inner_sta}, 16'd0);
        chk("rst_pwm", {15'd0, pwm_sta}, 16'd0);
        chk("rst_flags", {13'd0, busy, overrun, timeout}, 16'd0);
        chk("rst_step_count", step_count, 16'd0);
        rst = 1'b0;

        // Nominal step
        b = cyc + 2;
        push(0, b + 9); push(1, b + 31); push(2, b + 47); push(3, b + 96);
        at(b);      chk("nom_busy_pre", {15'd0, busy}, 16'd0); sta = 1'b1;
        at(b + 1);  chk("nom_busy_start", {15'd0, busy}, 16'd1);
        at(b + 40); pi_outer_done = 1'b1;
        at(b + 80); pi_inner_done = 1'b1;
        at(b + 96); steps++;
        chk("nom_busy_last", {15'd0, busy}, 16'd1);
        chk("nom_step_count", step_count, exp_steps());
        at(b + 97); chk("nom_busy_end", {15'd0, busy}, 16'd0);

        // Early outer done, with sta_user dropped mid-step
        b = cyc + 3;
        push(0, b + 9); push(1, b + 31); push(2, b + 32); push(3, b + 76);
        at(b);      sta = 1'b1;
        at(b + 12); pi_outer_done = 1'b1;
        at(b + 20); sta_user = 1'b0;
        at(b + 60); pi_inner_done = 1'b1;
        at(b + 76); steps++;
        chk("early_step_count", step_count, exp_steps());
        at(b + 77); chk("early_busy_end", {15'd0, busy}, 16'd0);
        sta_user = 1'b1;

        // Outer PI never answers
        b = cyc + 3;
        push(0, b + 9); push(1, b + 31);
        at(b);       sta = 1'b1;
        at(b + 263); chk("to_flag_before", {15'd0, timeout}, 16'd0);
        chk("to_busy_before", {15'd0, busy}, 16'd1);
        at(b + 264); chk("to_flag", {15'd0, timeout}, 16'd1);
        chk("to_busy_after", {15'd0, busy}, 16'd0);
        chk("to_step_count", step_count, exp_steps());
        at(b + 266); pi_inner_done = 1'b1;
        at(b + 268); rst_user = 1'b1; steps = 0;
        at(b + 269); chk("to_cleared", {15'd0, timeout}, 16'd0);
        chk("to_cnt_cleared", step_count, 16'd0);

        // Overrun during a nominal step, then a fresh step
        b = cyc + 3;
        push(0, b + 9);   push(1, b + 31);  push(2, b + 47);  push(3, b + 96);
        push(0, b + 109); push(1, b + 131); push(2, b + 147); push(3, b + 196);
        at(b);       sta = 1'b1;
        at(b + 40);  pi_outer_done = 1'b1;
        at(b + 50);  chk("ovr_before", {15'd0, overrun}, 16'd0); sta = 1'b1;
        at(b + 51);  chk("ovr_set", {15'd0, overrun}, 16'd1);
        at(b + 80);  pi_inner_done = 1'b1;
        at(b + 100); chk("ovr_idle", {15'd0, busy}, 16'd0); sta = 1'b1; steps++;
        at(b + 140); pi_outer_done = 1'b1;
        at(b + 180); pi_inner_done = 1'b1;
        at(b + 196); steps++;
        chk("ovr_step_count", step_count, exp_steps());
        at(b + 197); chk("ovr_sticky", {15'd0, overrun}, 16'd1);
        chk("ovr_busy_end", {15'd0, busy}, 16'd0);
        at(b + 198); rst_user = 1'b1; steps = 0;
        at(b + 199); chk("ovr_cleared", {15'd0, overrun}, 16'd0);

        // Gated sta and stray dones while idle
        b = cyc + 3;
        sta_user = 1'b0;
        at(b);      sta = 1'b1;
        at(b + 1);  chk("gate_busy", {15'd0, busy}, 16'd0);
        at(b + 5);  pi_inner_done = 1'b1;
        at(b + 6);  pi_outer_done = 1'b1;
        at(b + 40); chk("gate_flags", {13'd0, busy, overrun, timeout}, 16'd0);
        sta_user = 1'b1;

        // Soft reset mid-step
        b = cyc + 3;
        push(0, b + 9);
        at(b);      sta = 1'b1;
        at(b + 15); sta = 1'b1;
        at(b + 16); chk("sr_ovr_set", {15'd0, overrun}, 16'd1);
        at(b + 20); rst_user = 1'b1;
        at(b + 21); chk("sr_flags", {13'd0, busy, overrun, timeout}, 16'd0);
        chk("sr_step_count", step_count, 16'd0);
        at(b + 60); chk("sr_busy_late", {15'd0, busy}, 16'd0);

        at(cyc + 5);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pulses never seen, expected 0 (next %s at %0d)",
                     q.size(), kname[q[0].kind], q[0].at);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
